// File: rtl/bool_sched.sv
// bool_sched -- round-robin scheduler for a single shared boolean ALU.
//
// Accepts one request at a time from NREQ requesters over valid/ready and
// loads its opcode and operands into issue registers. These registers feed
// the shared boolean unit for one cycle. The unit's result is captured and
// returned on one response channel, tagged with the requester index.
//
// Optional feature macro: BOOL_SCHED_OPCHK_EN
//   defined   -> illegal opcodes are caught at accept. The unit sees AND with
//                zero operands, and the response carries data 0 and err 1.
//   undefined -> opcodes pass through unchecked and rsp_err is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester request valid
//   req_ready  out  [NREQ]     per-requester accept (one-hot or zero)
//   req_op     in   [4*NREQ]   packed opcodes, requester i at [4i+3:4i]
//   req_a      in   [32*NREQ]  packed operand A, requester i at [32i+31:32i]
//   req_b      in   [32*NREQ]  packed operand B, same slicing
//   bool_op    out  [4]        opcode to the shared unit
//   bool_a     out  [32]       operand A to the shared unit
//   bool_b     out  [32]       operand B to the shared unit
//   bool_y     in   [32]       combinational result from the shared unit
//   rsp_valid  out             response valid
//   rsp_ready  in              response accept
//   rsp_data   out  [32]       captured result
//   rsp_id     out  [IDW]      index of the issuing requester
//   rsp_err    out             illegal-opcode flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | scan requesters from rr_ptr, grant one and latch its request
// EXEC   | issue registers drive the shared unit; result captured at edge
// RESP   | response presented; held until rsp_ready

module bool_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [3:0]           bool_op,
  output logic [31:0]          bool_a,
  output logic [31:0]          bool_b,
  input  logic [31:0]          bool_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [3:0]     OP_AND  = 4'b1000;

  state_t          state;
  state_t          state_nxt;

  logic [IDW-1:0]  rr_ptr;
  logic            found;
  logic [IDW-1:0]  win;
  logic [3:0]      win_op;
  logic [31:0]     win_a;
  logic [31:0]     win_b;
  logic            accept;

  logic [IDW-1:0]  iss_id;
  logic [3:0]      iss_op;
  logic [31:0]     iss_a;
  logic [31:0]     iss_b;

  logic [31:0]     res_data;
  logic [IDW-1:0]  res_id;

`ifdef BOOL_SCHED_OPCHK_EN
  logic            iss_err;
  logic            res_err;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b1010, 4'b1000, 4'b0001, 4'b1110, 4'b1001, 4'b0110: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  endfunction
`endif

  // Winner search: first valid requester at or after rr_ptr, wrapping at
  // NREQ. Shifting the valid vector keeps the bit select at a fixed index.
  always_comb begin : p_pick
    logic [NREQ-1:0] rv_sh;
    int              idx;
    found = 1'b0;
    win   = '0;
    rv_sh = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NREQ;
      rv_sh = req_valid >> idx;
      if (!found && rv_sh[0]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Select the winner's fields out of the packed request buses.
  always_comb begin
    win_op = 4'(req_op >> {win, 2'b00});
    win_a  = 32'(req_a >> {win, 5'b00000});
    win_b  = 32'(req_b >> {win, 5'b00000});
  end

  assign accept = (state == S_IDLE) && found;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found)     state_nxt = S_EXEC;
      S_EXEC:                 state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (accept) begin
      req_ready = NREQ'(1) << win;
    end
    if (state == S_RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin pointer: the position after the last winner
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (win == LAST_ID) ? '0 : win + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Issue registers. They only load at accept, so the shared unit's
  // inputs stay frozen outside EXEC without any extra hold logic.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_id  <= '0;
      iss_op  <= '0;
      iss_a   <= '0;
      iss_b   <= '0;
`ifdef BOOL_SCHED_OPCHK_EN
      iss_err <= 1'b0;
`endif
    end else if (accept) begin
      iss_id  <= win;
`ifdef BOOL_SCHED_OPCHK_EN
      if (op_legal(win_op)) begin
        iss_op  <= win_op;
        iss_a   <= win_a;
        iss_b   <= win_b;
        iss_err <= 1'b0;
      end else begin
        // Drive a harmless AND of zeros so the unit still sees a legal op.
        iss_op  <= OP_AND;
        iss_a   <= '0;
        iss_b   <= '0;
        iss_err <= 1'b1;
      end
`else
      iss_op  <= win_op;
      iss_a   <= win_a;
      iss_b   <= win_b;
`endif
    end
  end

  assign bool_op = iss_op;
  assign bool_a  = iss_a;
  assign bool_b  = iss_b;

  // ---------------------------------------------------------------------
  // Result registers, loaded at the end of EXEC
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
`ifdef BOOL_SCHED_OPCHK_EN
      res_err  <= 1'b0;
`endif
    end else if (state == S_EXEC) begin
      res_id   <= iss_id;
`ifdef BOOL_SCHED_OPCHK_EN
      res_data <= iss_err ? 32'h0 : bool_y;
      res_err  <= iss_err;
`else
      res_data <= bool_y;
`endif
    end
  end

  assign rsp_data = res_data;
  assign rsp_id   = res_id;
`ifdef BOOL_SCHED_OPCHK_EN
  assign rsp_err  = res_err;
`else
  assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bool_sched.sv
module tb_bool_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
`ifdef BOOL_SCHED_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [4*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [3:0]          bool_op;
  logic [31:0]         bool_a;
  logic [31:0]         bool_b;
  logic [31:0]         bool_y;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;

  bool_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .bool_op   (bool_op),
    .bool_a    (bool_a),
    .bool_b    (bool_b),
    .bool_y    (bool_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared boolean unit that the scheduler sequences.
  always_comb begin
    case (bool_op)
      4'b1010: bool_y = bool_a;
      4'b1000: bool_y = bool_a & bool_b;
      4'b0001: bool_y = ~(bool_a | bool_b);
      4'b1110: bool_y = bool_a | bool_b;
      4'b1001: bool_y = ~(bool_a ^ bool_b);
      4'b0110: bool_y = bool_a ^ bool_b;
      default: bool_y = 32'h0;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[4*id +: 4]  = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  task automatic do_reset();
    step();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    bit          ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0]  exp_bop;
    logic [31:0] exp_ba;
    logic [31:0] exp_bb;
    logic [31:0] ready_exp;
    bit          forced;

    vecs[0] = '{0, 4'b0110, 32'hF0F0_0000, 32'hFF00_FF00, 32'h0FF0_FF00, 1'b0};
    vecs[1] = '{1, 4'b1000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0};
    vecs[2] = '{2, 4'b0001, 32'hF0F0_F0F0, 32'h0000_FFFF, 32'h0F0F_0000, 1'b0};
    vecs[3] = '{3, 4'b1110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[4] = '{1, 4'b1001, 32'hAAAA_5555, 32'hAAAA_AAAA, 32'hFFFF_0000, 1'b0};
    vecs[5] = '{0, 4'b1010, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{2, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset values
    step(); step(); #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_bool_op",   32'(bool_op),   32'h0);
    check("rst_bool_a",    bool_a,         32'h0);
    check("rst_bool_b",    bool_b,         32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  rsp_data,       32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_rsp_err",   32'(rsp_err),   32'h0);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      check("idle_req_ready", 32'(req_ready), 32'h0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    end

    // Table-driven single transactions
    foreach (vecs[i]) begin
      forced  = vecs[i].ill && OPCHK;
      exp_bop = forced ? 4'b1000 : vecs[i].op;
      exp_ba  = forced ? 32'h0 : vecs[i].a;
      exp_bb  = forced ? 32'h0 : vecs[i].b;
      step();
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      req_valid = NREQ'(1) << vecs[i].id;
      #1;
      check("vec_req_ready", 32'(req_ready), 32'(NREQ'(1) << vecs[i].id));
      step();
      req_valid = '0;
      #1;
      check("vec_exec_no_rsp", 32'(rsp_valid), 32'h0);
      check("vec_exec_ready",  32'(req_ready), 32'h0);
      check("vec_bool_op",     32'(bool_op),   32'(exp_bop));
      check("vec_bool_a",      bool_a,         exp_ba);
      check("vec_bool_b",      bool_b,         exp_bb);
      step(); #1;
      check("vec_rsp_valid", 32'(rsp_valid), 32'h1);
      check("vec_rsp_data",  rsp_data,       vecs[i].y);
      check("vec_rsp_id",    32'(rsp_id),    32'(vecs[i].id));
      check("vec_rsp_err",   32'(rsp_err),   32'(forced));
    end

    // Fairness: all requesters valid, pass-A of their own index
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'b1010, 32'(i), 32'h0);
    req_valid = '1;
    for (int k = 0; k < 15; k++) begin
      if (k != 0) step();
      #1;
      ready_exp = (k % 3 == 0) ? (32'h1 << ((k / 3) % 4)) : 32'h0;
      check("fair_grant", 32'(req_ready), ready_exp);
      if (k % 3 == 2) begin
        check("fair_rsp_valid", 32'(rsp_valid), 32'h1);
        check("fair_rsp_data",  rsp_data,       32'((k / 3) % 4));
        check("fair_rsp_id",    32'(rsp_id),    32'((k / 3) % 4));
      end
    end
    req_valid = '0;

    // Backpressure: response held for 10 cycles while req0 waits
    do_reset();
    set_req(1, 4'b1010, 32'h5A5A_5A5A, 32'h0);
    set_req(0, 4'b1010, 32'h1111_1111, 32'h0);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0001;
    #1;
    check("bp_exec_ready", 32'(req_ready), 32'h0);
    for (int j = 0; j < 10; j++) begin
      step(); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_data",  rsp_data,       32'h5A5A_5A5A);
      check("bp_rsp_id",    32'(rsp_id),    32'h1);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    step(); #1;
    check("bp_release_grant0", 32'(req_ready), 32'h1);
    check("bp_release_idle",   32'(rsp_valid), 32'h0);
    step();
    req_valid = '0;
    step(); #1;
    check("bp_next_rsp_data", rsp_data,    32'h1111_1111);
    check("bp_next_rsp_id",   32'(rsp_id), 32'h0);

    // Reset during EXEC drops the transaction and clears rr_ptr
    do_reset();
    set_req(1, 4'b1010, 32'hCAFE_F00D, 32'h0);
    req_valid = 4'b0010;
    #1;
    check("rx_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rx_in_reset_rsp", 32'(rsp_valid), 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rx_no_rsp", 32'(rsp_valid), 32'h0);
      step();
    end
    set_req(0, 4'b1010, 32'h0000_00A0, 32'h0);
    set_req(3, 4'b1010, 32'h0000_0B03, 32'h0);
    req_valid = 4'b1001;
    #1;
    check("rx_ptr_zero_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b1000;
    #1;
    check("rx_exec_ready", 32'(req_ready), 32'h0);
    step(); #1;
    check("rx_rsp0_id",   32'(rsp_id), 32'h0);
    check("rx_rsp0_data", rsp_data,    32'h0000_00A0);
    step(); #1;
    check("rx_grant3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    #1;
    check("rx_req3_exec", 32'(rsp_valid), 32'h0);
    step(); #1;
    check("rx_rsp3_valid", 32'(rsp_valid), 32'h1);
    check("rx_rsp3_id",    32'(rsp_id),    32'h3);
    check("rx_rsp3_data",  rsp_data,       32'h0000_0B03);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
